// File: rtl/sdu_pkg.sv
// Shared constants for the debug-unit memory dump sequencer: FSM state codes,
// ASCII framing characters and read-source selector codes.
package sdu_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_PFX  = 3'd3;
  localparam logic [2:0] ST_DAT  = 3'd4;
  localparam logic [2:0] ST_SEP  = 3'd5;
  localparam logic [2:0] ST_EOL  = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  localparam logic [1:0] SRC_DM = 2'd0;
  localparam logic [1:0] SRC_IM = 2'd1;
  localparam logic [1:0] SRC_RF = 2'd2;

  // States that present a byte to the TX serialiser.
  function automatic logic is_emit_state(input logic [2:0] s);
    return (s == ST_PFX) || (s == ST_DAT) || (s == ST_SEP) || (s == ST_EOL);
  endfunction

endpackage

// File: rtl/sdu_mem_dump_if.sv
// Bundle of command, shared debug read port and TX byte handshake signals
// for the dump sequencer; master is the sequencer side.
interface sdu_mem_dump_if;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic [1:0]  src_sel;
  logic [31:0] addr;
  logic [31:0] dout_dm;
  logic [31:0] dout_im;
  logic [31:0] dout_rf;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;
  logic        busy;
  logic        done;
  logic        aborted;

  modport master (
    input  start, abort, base_addr, count, src_sel,
    input  dout_dm, dout_im, dout_rf, rdy_tx,
    output addr, d_tx, vld_tx, busy, done, aborted
  );

  modport slave (
    output start, abort, base_addr, count, src_sel,
    output dout_dm, dout_im, dout_rf, rdy_tx,
    input  addr, d_tx, vld_tx, busy, done, aborted
  );
endinterface

// File: rtl/sdu_hex_nib.sv
// Combinational 4-bit to uppercase ASCII hex digit converter.
module sdu_hex_nib (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  always_comb begin
    if (nib < 4'd10) ascii = 8'h30 + {4'd0, nib};
    else             ascii = 8'h37 + {4'd0, nib};  // 'A' - 10
  end
endmodule

// File: rtl/sdu_mem_dump.sv
// Debug-unit dump sequencer: walks a memory range and streams ASCII hex lines to TX.
// Optional feature: SDU_DUMP_ADDR_PREFIX_EN adds an "AAAAAAAA: " prefix to each line.
module sdu_mem_dump
  import sdu_pkg::*;
#(
  parameter int unsigned WPL       = 4,
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned RD_LAT    = 0
) (
  input logic            clk,
  input logic            rst,
  sdu_mem_dump_if.master bus
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] words_left_q, words_left_d;
  logic [4:0]  line_words_q, line_words_d;
  logic [1:0]  src_q, src_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        abort_pend_q, abort_pend_d;
  logic [7:0]  d_tx_q, d_tx_d;
  logic        vld_tx_q, vld_tx_d;
`ifdef SDU_DUMP_ADDR_PREFIX_EN
  logic [31:0] line_addr_q, line_addr_d;
`endif

  logic [31:0] src_word;
  logic [31:0] nib_src;
  logic [31:0] addr_inc;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic [7:0]  nib_ascii;
  logic        xfer;
  logic        abort_req;

  assign xfer      = vld_tx_q & bus.rdy_tx;
  assign addr_inc  = addr_q + 32'(ADDR_STEP);
  assign abort_req = (state_q != ST_IDLE) && (state_q != ST_DONE) && (bus.abort || abort_pend_q);

  always_comb begin
    case (src_q)
      SRC_DM:  src_word = bus.dout_dm;
      SRC_IM:  src_word = bus.dout_im;
      SRC_RF:  src_word = bus.dout_rf;
      default: src_word = 32'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    word_d       = word_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    line_words_d = line_words_q;
    src_d        = src_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
`ifdef SDU_DUMP_ADDR_PREFIX_EN
    line_addr_d  = line_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d       = bus.base_addr;
          words_left_d = bus.count;
          src_d        = bus.src_sel;
          line_words_d = 5'd0;
          idx_d        = 4'd0;
          lat_d        = 2'd0;
          busy_d       = 1'b1;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (bus.count == 16'd0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        if (lat_q == 2'(RD_LAT)) begin
          lat_d   = 2'd0;
          state_d = ST_CAP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_CAP: begin
        word_d = src_word;
        idx_d  = 4'd0;
`ifdef SDU_DUMP_ADDR_PREFIX_EN
        if (line_words_q == 5'd0) begin
          line_addr_d = addr_q;
          state_d     = ST_PFX;
        end else begin
          state_d = ST_DAT;
        end
`else
        state_d = ST_DAT;
`endif
      end
`ifdef SDU_DUMP_ADDR_PREFIX_EN
      ST_PFX: begin
        if (xfer) begin
          if (idx_q == 4'd9) begin
            idx_d   = 4'd0;
            state_d = ST_DAT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`endif
      ST_DAT: begin
        if (xfer) begin
          if (idx_q == 4'd7) begin
            idx_d        = 4'd0;
            line_words_d = line_words_q + 5'd1;
            words_left_d = words_left_q - 16'd1;
            // No separator after the last word of a line or of the dump.
            if ((words_left_q == 16'd1) || (line_words_q + 5'd1 == 5'(WPL))) state_d = ST_EOL;
            else                                                              state_d = ST_SEP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_SEP: begin
        if (xfer) begin
          addr_d  = addr_inc;
          state_d = ST_RD;
        end
      end
      ST_EOL: begin
        if (xfer) begin
          if (idx_q == 4'd0) begin
            idx_d = 4'd1;
          end else begin
            idx_d        = 4'd0;
            line_words_d = 5'd0;
            if (words_left_q == 16'd0) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_inc;
              state_d = ST_RD;
            end
          end
        end
      end
      ST_DONE: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        aborted_d    = abort_pend_q;
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort is remembered so a short pulse still ends the dump once a pending byte leaves.
    if (abort_req) begin
      abort_pend_d = 1'b1;
      if (!vld_tx_q || bus.rdy_tx) state_d = ST_DONE;
    end
  end

  // Single hex converter shared by prefix and data bytes; only the source word differs.
`ifdef SDU_DUMP_ADDR_PREFIX_EN
  assign nib_src = (state_d == ST_PFX) ? line_addr_d : word_d;
`else
  assign nib_src = word_d;
`endif
  assign nib_sel = 3'd7 - idx_d[2:0];
  assign nib     = nib_src[{nib_sel, 2'b00} +: 4];

  sdu_hex_nib u_hex_nib (
    .nib   (nib),
    .ascii (nib_ascii)
  );

  always_comb begin
    vld_tx_d = is_emit_state(state_d);
    d_tx_d   = d_tx_q;
    case (state_d)
`ifdef SDU_DUMP_ADDR_PREFIX_EN
      ST_PFX: begin
        if (idx_d < 4'd8)       d_tx_d = nib_ascii;
        else if (idx_d == 4'd8) d_tx_d = ASCII_COLON;
        else                    d_tx_d = ASCII_SP;
      end
`endif
      ST_DAT:  d_tx_d = nib_ascii;
      ST_SEP:  d_tx_d = ASCII_SP;
      ST_EOL:  d_tx_d = (idx_d == 4'd0) ? ASCII_CR : ASCII_LF;
      default: d_tx_d = d_tx_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      lat_q        <= 2'd0;
      word_q       <= 32'd0;
      addr_q       <= 32'd0;
      words_left_q <= 16'd0;
      line_words_q <= 5'd0;
      src_q        <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      d_tx_q       <= 8'd0;
      vld_tx_q     <= 1'b0;
`ifdef SDU_DUMP_ADDR_PREFIX_EN
      line_addr_q  <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      line_words_q <= line_words_d;
      src_q        <= src_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      d_tx_q       <= d_tx_d;
      vld_tx_q     <= vld_tx_d;
`ifdef SDU_DUMP_ADDR_PREFIX_EN
      line_addr_q  <= line_addr_d;
`endif
    end
  end

  assign bus.addr    = addr_q;
  assign bus.d_tx    = d_tx_q;
  assign bus.vld_tx  = vld_tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_sdu_mem_dump.sv
// Directed bench for sdu_mem_dump: three instances cover WPL/RD_LAT variants;
// the TX byte stream is collected and compared against hand-written strings.
module tb_sdu_mem_dump;

  logic        clk;
  logic        rst;
  logic [2:0]  start_r;
  logic        abort_r;
  logic [31:0] base_r;
  logic [15:0] count_r;
  logic [1:0]  src_r;
  logic        rdy_r;
  int          sel;

  int tests_run;
  int tests_failed;

  logic [7:0] rxq[$];
  logic [7:0] exq[$];

  sdu_mem_dump_if if_a ();
  sdu_mem_dump_if if_b ();
  sdu_mem_dump_if if_c ();

  function automatic logic [31:0] dm_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    if (a == 32'h11) return 32'h00000001;
    return a * 32'h01010101;
  endfunction
  function automatic logic [31:0] im_f(input logic [31:0] a);
    return ~a;
  endfunction
  function automatic logic [31:0] rf_f(input logic [31:0] a);
    return a ^ 32'hA5A50F0F;
  endfunction

  assign if_a.start = start_r[0];  assign if_b.start = start_r[1];  assign if_c.start = start_r[2];
  assign if_a.abort = abort_r;     assign if_b.abort = abort_r;     assign if_c.abort = abort_r;
  assign if_a.base_addr = base_r;  assign if_b.base_addr = base_r;  assign if_c.base_addr = base_r;
  assign if_a.count = count_r;     assign if_b.count = count_r;     assign if_c.count = count_r;
  assign if_a.src_sel = src_r;     assign if_b.src_sel = src_r;     assign if_c.src_sel = src_r;
  assign if_a.rdy_tx = rdy_r;      assign if_b.rdy_tx = rdy_r;      assign if_c.rdy_tx = rdy_r;
  assign if_a.dout_dm = dm_f(if_a.addr);
  assign if_a.dout_im = im_f(if_a.addr);
  assign if_a.dout_rf = rf_f(if_a.addr);
  assign if_b.dout_dm = dm_f(if_b.addr);
  assign if_b.dout_im = im_f(if_b.addr);
  assign if_b.dout_rf = rf_f(if_b.addr);
  assign if_c.dout_dm = dm_f(if_c.addr);
  assign if_c.dout_im = im_f(if_c.addr);
  assign if_c.dout_rf = rf_f(if_c.addr);

  sdu_mem_dump #(.WPL(4), .ADDR_STEP(1), .RD_LAT(0)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.master));
  sdu_mem_dump #(.WPL(2), .ADDR_STEP(1), .RD_LAT(1)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.master));
  sdu_mem_dump #(.WPL(1), .ADDR_STEP(1), .RD_LAT(2)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c.master));

  logic        vld_s, busy_s, done_s, aborted_s;
  logic [7:0]  d_s;
  logic [31:0] addr_s;

  always_comb begin
    vld_s = if_a.vld_tx; d_s = if_a.d_tx; busy_s = if_a.busy;
    done_s = if_a.done; aborted_s = if_a.aborted; addr_s = if_a.addr;
    if (sel == 1) begin
      vld_s = if_b.vld_tx; d_s = if_b.d_tx; busy_s = if_b.busy;
      done_s = if_b.done; aborted_s = if_b.aborted; addr_s = if_b.addr;
    end else if (sel == 2) begin
      vld_s = if_c.vld_tx; d_s = if_c.d_tx; busy_s = if_c.busy;
      done_s = if_c.done; aborted_s = if_c.aborted; addr_s = if_c.addr;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs change only at posedge+1, so a negedge sample shows what the next edge will take.
  logic       prev_hold;
  logic [7:0] prev_d;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) check("tx_hold", 32'({vld_s, d_s}), 32'({1'b1, prev_d}));
      if (vld_s && rdy_r) rxq.push_back(d_s);
      prev_hold <= vld_s && !rdy_r;
      prev_d    <= d_s;
    end
  end

  task automatic exp_s(input string s);
    for (int i = 0; i < s.len(); i++) exq.push_back(s[i]);
  endtask
  task automatic exp_crlf();
    exq.push_back(8'h0D);
    exq.push_back(8'h0A);
  endtask
  task automatic exp_pfx(input logic [31:0] a);
`ifdef SDU_DUMP_ADDR_PREFIX_EN
    exp_s($sformatf("%08X: ", a));
`else
    if (a == 32'hFFFF_FFFF) exq = exq;  // data-only lines carry no prefix
`endif
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check($sformatf("%s_len", tag), 32'(rxq.size()), 32'(exq.size()));
    n = (rxq.size() < exq.size()) ? rxq.size() : exq.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 32'(rxq[i]), 32'(exq[i]));
  endtask

  task automatic do_start(input int which, input logic [31:0] b, input logic [15:0] c,
                          input logic [1:0] s);
    @(posedge clk); #1;
    base_r = b; count_r = c; src_r = s;
    start_r = 3'b000;
    start_r[which] = 1'b1;
    @(posedge clk); #1;
    start_r = 3'b000;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit saw_vld);
    cyc = 0; saw_vld = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (vld_s) saw_vld = 1'b1;
      if (done_s) break;
    end
  endtask

  task automatic new_test(input int s);
    @(posedge clk); #1;
    sel = s;
    rxq.delete();
    exq.delete();
  endtask

  int cyc;
  bit saw_vld;
  bit got_done;

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; start_r = 3'b000; abort_r = 1'b0; base_r = 32'd0;
    count_r = 16'd0; src_r = 2'd0; rdy_r = 1'b1; sel = 0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_vld", 32'(if_a.vld_tx), 32'd0);
    check("rst_dtx", 32'(if_a.d_tx), 32'd0);
    check("rst_addr", if_a.addr, 32'd0);
    check("rst_busy_done_ab", 32'({if_a.busy, if_a.done, if_a.aborted}), 32'd0);
    rst = 1'b0;

    // 1: two DM words on one line, first byte latency
    new_test(0);
    do_start(0, 32'h10, 16'd2, 2'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("t1_busy", 32'(busy_s), 32'd1);
    end while (!vld_s && cyc < 20);
    check("t1_latency", cyc, 32'd3);
    wait_done(200, cyc, saw_vld);
    check("t1_done", 32'(done_s), 32'd1);
    check("t1_aborted", 32'(aborted_s), 32'd0);
    check("t1_busy_low", 32'(busy_s), 32'd0);
    exp_pfx(32'h10); exp_s("DEADBEEF 00000001"); exp_crlf();
    compare_stream("t1");
    @(negedge clk);
    check("t1_done_pulse", 32'(done_s), 32'd0);

    // 2: five IM words, two per line, RD_LAT=1
    new_test(1);
    do_start(1, 32'h20, 16'd5, 2'd1);
    wait_done(500, cyc, saw_vld);
    check("t2_done", 32'(done_s), 32'd1);
    exp_pfx(32'h20); exp_s("FFFFFFDF FFFFFFDE"); exp_crlf();
    exp_pfx(32'h22); exp_s("FFFFFFDD FFFFFFDC"); exp_crlf();
    exp_pfx(32'h24); exp_s("FFFFFFDB"); exp_crlf();
    compare_stream("t2");

    // 3: random backpressure, same stream as test 1
    new_test(0);
    do_start(0, 32'h10, 16'd2, 2'd0);
    got_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rdy_r = 1'($urandom_range(0, 1));
      if (done_s) begin
        got_done = 1'b1;
        break;
      end
    end
    rdy_r = 1'b1;
    check("t3_done", 32'(got_done), 32'd1);
    exp_pfx(32'h10); exp_s("DEADBEEF 00000001"); exp_crlf();
    compare_stream("t3");

    // 4: abort pulse while the third byte is pending
    new_test(0);
    rdy_r = 1'b0;
    do_start(0, 32'h10, 16'd2, 2'd0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!vld_s && cyc < 20);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 rdy_r = 1'b1;
      @(posedge clk); #1 rdy_r = 1'b0;
    end
    abort_r = 1'b1;
    @(posedge clk); #1 abort_r = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_r = 1'b1;
    wait_done(50, cyc, saw_vld);
    check("t4_done", 32'(done_s), 32'd1);
    check("t4_aborted", 32'(aborted_s), 32'd1);
`ifdef SDU_DUMP_ADDR_PREFIX_EN
    exp_s("000");
`else
    exp_s("DEA");
`endif
    repeat (4) @(negedge clk);
    check("t4_aborted_held", 32'(aborted_s), 32'd1);
    compare_stream("t4");

    // 5: count=0 finishes without bytes; start while busy is ignored
    new_test(0);
    do_start(0, 32'h10, 16'd0, 2'd0);
    wait_done(20, cyc, saw_vld);
    check("t5_done_cycles", cyc, 32'd2);
    check("t5_no_vld", 32'(saw_vld), 32'd0);
    check("t5_aborted_clr", 32'(aborted_s), 32'd0);
    do_start(0, 32'h10, 16'd2, 2'd0);
    repeat (2) @(posedge clk);
    do_start(0, 32'h99, 16'd1, 2'd2);
    wait_done(200, cyc, saw_vld);
    check("t5_done", 32'(done_s), 32'd1);
    exp_pfx(32'h10); exp_s("DEADBEEF 00000001"); exp_crlf();
    compare_stream("t5");

    // 6: RF source, address wrap, one word per line, RD_LAT=2
    new_test(2);
    do_start(2, 32'hFFFF_FFFF, 16'd2, 2'd2);
    wait_done(200, cyc, saw_vld);
    check("t6_done", 32'(done_s), 32'd1);
    check("t6_addr_wrap", addr_s, 32'h0000_0000);
    exp_pfx(32'hFFFF_FFFF); exp_s("5A5AF0F0"); exp_crlf();
    exp_pfx(32'h0000_0000); exp_s("A5A50F0F"); exp_crlf();
    compare_stream("t6");

    // 7: reserved source reads as zero
    new_test(0);
    do_start(0, 32'h40, 16'd1, 2'd3);
    wait_done(200, cyc, saw_vld);
    check("t7_done", 32'(done_s), 32'd1);
    exp_pfx(32'h40); exp_s("00000000"); exp_crlf();
    compare_stream("t7");

    // 8: reset mid-dump drops vld_tx without a clock edge
    new_test(0);
    rdy_r = 1'b0;
    do_start(0, 32'h10, 16'd2, 2'd0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!vld_s && cyc < 20);
    check("t8_vld_before", 32'(vld_s), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t8_vld_async", 32'(vld_s), 32'd0);
    check("t8_busy_async", 32'(busy_s), 32'd0);
    check("t8_addr_async", addr_s, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rdy_r = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
